// File: rtl/fir_out_receiver.sv
// Receives 11-bit FIR samples into a small FIFO and serializes each as two AXI-Stream bytes.
// Optional peak-magnitude tracking is built only when FIR_RX_PEAK_EN is defined.
module fir_out_receiver #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] s_axis_fir_tdata,
   input  logic        s_axis_fir_tvalid,
   output logic        s_axis_fir_tready,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   input  logic        clr_stat,
   output logic        overflow,
   output logic [10:0] peak_abs
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

   logic [10:0]   mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q, count_d;
   logic          full, empty, push, pop, drop;
   logic [10:0]   head;

   state_e        state_q, state_d;
   logic [10:0]   hold_q, hold_d;
   logic [7:0]    tdata_q, tdata_d;
   logic          tvalid_q, tvalid_d;
   logic          tlast_q, tlast_d;
   logic          ovf_q, ovf_d;

   assign full              = (count_q == FULL_CNT);
   assign empty             = (count_q == '0);
   assign s_axis_fir_tready = !full;
   assign push              = s_axis_fir_tvalid && !full;
   assign drop              = s_axis_fir_tvalid && full;
   assign head              = mem_q[rptr_q];

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign overflow      = ovf_q;

   // Sample storage needs no reset; occupancy alone defines valid entries.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= s_axis_fir_tdata;
      end
   end

   always_comb begin
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   end

   always_comb begin
      ovf_d = ovf_q;
      if (clr_stat) begin
         ovf_d = 1'b0;
      end
      if (drop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Entering LO from IDLE takes an extra cycle: tvalid_q low in LO means the
   // low byte has not been presented yet.
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      pop      = 1'b0;
      unique case (state_q)
         StIdle: begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            if (!empty) begin
               pop     = 1'b1;
               hold_d  = head;
               state_d = StLo;
            end
         end
         StLo: begin
            if (!tvalid_q) begin
               tvalid_d = 1'b1;
               tdata_d  = hold_q[7:0];
               tlast_d  = 1'b0;
            end else if (m_axis_tready) begin
               state_d = StHi;
               tdata_d = {{5{hold_q[10]}}, hold_q[10:8]};
               tlast_d = 1'b1;
            end
         end
         StHi: begin
            if (m_axis_tready) begin
               if (!empty) begin
                  pop     = 1'b1;
                  hold_d  = head;
                  state_d = StLo;
                  tdata_d = head[7:0];
                  tlast_d = 1'b0;
               end else begin
                  state_d  = StIdle;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  tdata_d  = '0;
               end
            end
         end
         default: begin
            state_d  = StIdle;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         hold_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
      end
   end

`ifdef FIR_RX_PEAK_EN
   logic [10:0] abs_s, peak_q, peak_d;

   // Magnitude of -1024 wraps to 11'h400, which reads as 1024 unsigned.
   assign abs_s = s_axis_fir_tdata[10] ? (~s_axis_fir_tdata + 11'd1) : s_axis_fir_tdata;

   always_comb begin
      peak_d = peak_q;
      if (clr_stat) begin
         peak_d = '0;
      end
      if (push && (clr_stat || (abs_s > peak_q))) begin
         peak_d = abs_s;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         peak_q <= '0;
      end else begin
         peak_q <= peak_d;
      end
   end

   assign peak_abs = peak_q;
`else
   assign peak_abs = '0;
`endif

endmodule

// File: tb/tb_fir_out_receiver.sv
// Directed bench for fir_out_receiver: scoreboard of expected output bytes plus immediate assertions.
module tb_fir_out_receiver;

   logic        clk;
   logic        reset;
   logic [10:0] s_axis_fir_tdata;
   logic        s_axis_fir_tvalid;
   logic        s_axis_fir_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic        clr_stat;
   logic        overflow;
   logic [10:0] peak_abs;

   int total = 0;
   int bad   = 0;
   logic [8:0] sb[$];

   fir_out_receiver #(.DEPTH(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .s_axis_fir_tdata  (s_axis_fir_tdata),
      .s_axis_fir_tvalid (s_axis_fir_tvalid),
      .s_axis_fir_tready (s_axis_fir_tready),
      .m_axis_tdata      (m_axis_tdata),
      .m_axis_tvalid     (m_axis_tvalid),
      .m_axis_tlast      (m_axis_tlast),
      .m_axis_tready     (m_axis_tready),
      .clr_stat          (clr_stat),
      .overflow          (overflow),
      .peak_abs          (peak_abs)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_push(input logic [10:0] s);
      sb.push_back({1'b0, s[7:0]});
      sb.push_back({1'b1, {5{s[10]}}, s[10:8]});
   endtask

   task automatic push_sample(input logic [10:0] s);
      s_axis_fir_tvalid = 1'b1;
      s_axis_fir_tdata  = s;
      check("push_ready", {31'd0, s_axis_fir_tready}, 32'd1);
      if (s_axis_fir_tready) sb_push(s);
      step();
      s_axis_fir_tvalid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      m_axis_tready = 1'b1;
      while ((sb.size() != 0 || m_axis_tvalid) && n < budget) begin
         step();
         n++;
      end
      check("drain", {31'd0, (sb.size() == 0 && !m_axis_tvalid)}, 32'd1);
   endtask

   // Outputs settle by mid-cycle; a handshake seen here completes at the next rising edge.
   always @(negedge clk) begin
      if (!reset && m_axis_tvalid && m_axis_tready) begin
         logic [8:0] exp_b;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $error("FAIL stale_byte obs=%0h exp=none", {m_axis_tlast, m_axis_tdata});
         end else begin
            exp_b = sb.pop_front();
            assert ({m_axis_tlast, m_axis_tdata} === exp_b) else begin
               bad++;
               $error("FAIL sb_byte obs=%0h exp=%0h", {m_axis_tlast, m_axis_tdata}, exp_b);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      s_axis_fir_tdata = '0;
      s_axis_fir_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      clr_stat = 1'b0;
      step();
      step();
      check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
      check("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      check("rst_peak", {21'd0, peak_abs}, 32'd0);
      check("rst_ready", {31'd0, s_axis_fir_tready}, 32'd1);
      reset = 1'b0;
      step();

      // Single sample latency and byte layout
      push_sample(11'h5A3);
      check("lat_n0", {31'd0, m_axis_tvalid}, 32'd0);
      step();
      check("lat_n1", {31'd0, m_axis_tvalid}, 32'd0);
      step();
      check("lat_n2", {22'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {22'd0, 2'b10, 8'hA3});
      step();
      check("lat_hi", {22'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {22'd0, 2'b11, 8'hFD});
      step();
      check("lat_idle", {31'd0, m_axis_tvalid}, 32'd0);

      // Backpressure in LO
      m_axis_tready = 1'b0;
      push_sample(11'h5A3);
      step();
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_hold", {22'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
               {22'd0, 2'b10, 8'hA3});
      end
      m_axis_tready = 1'b1;
      step();
      check("bp_hi", {22'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {22'd0, 2'b11, 8'hFD});
      drain(10);

      // Overflow: 4 FIFO slots plus the hold register
      m_axis_tready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         s_axis_fir_tvalid = 1'b1;
         s_axis_fir_tdata  = 11'(16 + i);
         check("ovf_ready", {31'd0, s_axis_fir_tready}, (i < 5) ? 32'd1 : 32'd0);
         if (s_axis_fir_tready) sb_push(11'(16 + i));
         step();
      end
      s_axis_fir_tvalid = 1'b0;
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      check("ovf_full", {31'd0, s_axis_fir_tready}, 32'd0);
      clr_stat = 1'b1;
      step();
      clr_stat = 1'b0;
      check("ovf_clr", {31'd0, overflow}, 32'd0);
      check("peak_clr0", {21'd0, peak_abs}, 32'd0);
      drain(40);

      // Peak magnitude
      push_sample(11'h100);
      push_sample(11'h400);
      push_sample(11'h3FF);
`ifdef FIR_RX_PEAK_EN
      check("peak_max", {21'd0, peak_abs}, 32'd1024);
`else
      check("peak_off", {21'd0, peak_abs}, 32'd0);
`endif
      clr_stat = 1'b1;
      step();
      clr_stat = 1'b0;
      check("peak_clr", {21'd0, peak_abs}, 32'd0);
      push_sample(11'h400);
      clr_stat = 1'b1;
      push_sample(11'h7FF);
      clr_stat = 1'b0;
`ifdef FIR_RX_PEAK_EN
      check("peak_clr_push", {21'd0, peak_abs}, 32'd1);
`else
      check("peak_off2", {21'd0, peak_abs}, 32'd0);
`endif
      drain(40);

      // Ordering and pointer wrap under random backpressure
      for (int i = 0; i < 20; i++) begin
         int tries = 0;
         s_axis_fir_tvalid = 1'b1;
         s_axis_fir_tdata  = 11'(i);
         while (!s_axis_fir_tready && tries < 50) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            step();
            tries++;
         end
         check("ord_accept", {31'd0, s_axis_fir_tready}, 32'd1);
         if (s_axis_fir_tready) sb_push(11'(i));
         m_axis_tready = 1'($urandom_range(0, 1));
         step();
      end
      s_axis_fir_tvalid = 1'b0;
      drain(200);

      // Reset during HI with two samples queued
      m_axis_tready = 1'b0;
      push_sample(11'h0AA);
      push_sample(11'h0BB);
      push_sample(11'h0CC);
      step();
      step();
      check("rh_lo", {22'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {22'd0, 2'b10, 8'hAA});
      m_axis_tready = 1'b1;
      step();
      m_axis_tready = 1'b0;
      check("rh_hi", {31'd0, m_axis_tlast}, 32'd1);
      reset = 1'b1;
      #1;
      check("rh_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      sb.delete();
      step();
      check("rh_ready", {31'd0, s_axis_fir_tready}, 32'd1);
      reset = 1'b0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("rh_quiet", {31'd0, m_axis_tvalid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_out_receiver.md
FIR_OUT_RECEIVER -- requirements
Module: fir_out_receiver

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of 11-bit sample slots in the receive FIFO; legal values are 2, 4 and 8.
REQ-002 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-004 s_axis_fir_tdata  in  11  SHALL carry the FIR output sample, two's complement.
REQ-005 s_axis_fir_tvalid  in  1  SHALL qualify s_axis_fir_tdata.
REQ-006 s_axis_fir_tready  out  1  SHALL be high when the FIFO is not full.
REQ-007 m_axis_tdata  out  8  SHALL carry the serialized output byte.
REQ-008 m_axis_tvalid  out  1  SHALL qualify m_axis_tdata.
REQ-009 m_axis_tlast  out  1  SHALL mark the second (high) byte of a sample.
REQ-010 m_axis_tready  in  1  SHALL be the downstream accept.
REQ-011 clr_stat  in  1  SHALL synchronously clear the overflow flag and the peak register.
REQ-012 overflow  out  1  SHALL be the sticky dropped-sample flag.
REQ-013 peak_abs  out  11  SHALL be the peak absolute sample value (see REQ-027).

Function
REQ-014 Push occurs on an edge where s_axis_fir_tvalid=1 and s_axis_fir_tready=1; the FIFO preserves order.
REQ-015 s_axis_fir_tready SHALL be computed combinationally as !full; when full, a push is refused even if a pop occurs in the same cycle.
REQ-016 On an edge where s_axis_fir_tvalid=1 and full=1, the sample SHALL be dropped and overflow set to 1, remaining set until clr_stat or reset.
REQ-017 If clr_stat and a drop occur on the same edge, overflow SHALL end at 1 (set wins).
REQ-018 A simultaneous push and pop on a non-full FIFO SHALL leave the occupancy unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-019 Output FSM states: IDLE, LO, HI.
REQ-020 IDLE: if the FIFO is non-empty, the FSM SHALL pop the head into the hold register and go to LO; otherwise it stays in IDLE with m_axis_tvalid=0.
REQ-021 LO: m_axis_tvalid=1, m_axis_tdata=hold[7:0], m_axis_tlast=0; on m_axis_tready=1 go to HI; otherwise hold all outputs stable.
REQ-022 HI: m_axis_tvalid=1, m_axis_tdata={5 copies of hold[10], hold[10:8]}, m_axis_tlast=1; on m_axis_tready=1, pop the next sample and go to LO if the FIFO is non-empty, else go to IDLE.
REQ-023 Latency: a sample pushed into an empty FIFO while the FSM is in IDLE at edge N SHALL present its low byte with m_axis_tvalid=1 after edge N+2.
REQ-024 Sustained throughput SHALL be one sample per two cycles with m_axis_tready held at 1; the input therefore requires back-to-back upstream gaps or FIFO slack.
REQ-025 m_axis_tdata/tvalid/tlast SHALL be registered outputs with no combinational path from m_axis_tready.

Reset
REQ-026 While reset=1: FIFO empty, FSM=IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overflow=0, peak_abs=0, s_axis_fir_tready=1; a reset asserted mid-sample SHALL discard the hold register and all FIFO contents.

Configuration
REQ-027 With FIR_RX_PEAK_EN defined, peak_abs SHALL update on each push to max(peak_abs, |sample|) as an 11-bit unsigned value (|-1024|=1024), and clr_stat SHALL zero it; a push coinciding with clr_stat loads |sample|.
REQ-028 Without FIR_RX_PEAK_EN, peak_abs SHALL be tied to 0 and no peak logic SHALL be synthesized.

Verification
REQ-029 Single sample: push 11'h5A3 into an empty FIFO with m_axis_tready=1 -> bytes 8'hA3 (tlast=0) then 8'hFD (tlast=1), first byte valid at N+2.
REQ-030 Backpressure: m_axis_tready=0 for 10 cycles during LO -> m_axis_tdata stays 8'hA3 with tvalid=1; release -> HI byte on the next cycle.
REQ-031 Overflow: DEPTH=4, m_axis_tready=0, push 6 samples -> s_axis_fir_tready=0 after the 5th accepted (4 FIFO + 1 hold), 6th dropped, overflow=1; clr_stat -> overflow=0.
REQ-032 Ordering/wrap: stream 20 samples 0..19 with random m_axis_tready -> output low bytes 0..19 in order, none lost.
REQ-033 Peak (macro on): push 11'h100, 11'h400 (-1024), 11'h3FF -> peak_abs=1024; clr_stat -> 0; macro off -> peak_abs always 0.
REQ-034 Reset mid-HI: assert reset during HI with 2 samples queued -> tvalid=0 immediately, FIFO empty, no stale bytes emitted after release.
